dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//  Downstream of the MEM-stage load/store aligner. Takes its word-aligned request
//  (addr, cmd, write_data, write_mask) and runs one transaction at a time on a
//  valid/ready data bus with variable wait states.
//  Returns the raw load word to the aligner, stalls the pipeline while busy, and
//  flags bus errors and timeouts.
// PARAMETERS
//  TIMEOUT   256  cycles in ISSUE+WAIT before forced abort (>=2)
//  TO_W      8    timeout counter width; must satisfy 2**TO_W >= TIMEOUT
// PORTS
//  clk            in   1   core clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  cpu_req        in   1   MEM stage holds a load/store this cycle
//  cpu_cmd        in   1   1=store, 0=load
//  cpu_addr       in   32  byte address; bits[1:0] ignored
//  cpu_wdata      in   32  lane-positioned store data
//  cpu_wmask      in   4   byte-lane enables for stores
//  cpu_stall      out  1   freeze pipeline
//  cpu_rdata      out  32  raw load word, fed to aligner load_data
//  cpu_done       out  1   1-cycle pulse: transaction complete
//  cpu_fault      out  1   valid with cpu_done: bus error or timeout
//  bus_req_valid  out  1   request valid
//  bus_req_ready  in   1   bus accepts request
//  bus_addr       out  32  {addr[31:2],2'b00}
//  bus_we         out  1   write enable
//  bus_wdata      out  32  store data
//  bus_wstrb      out  4   byte strobes
//  bus_resp_valid in   1   response valid (loads and stores both respond)
//  bus_rdata      in   32  load data
//  bus_resp_err   in   1   response carries error
// BEHAVIOUR
//  Reset (async): state=IDLE, all outputs 0, request regs 0, counter 0.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE: cpu_req=1 -> capture addr/cmd/wdata/wmask -> ISSUE.
//   Exception: store with wmask=0 -> DONE directly; no bus access, fault=0.
//  ISSUE: bus_req_valid=1; bus_* driven from captured regs, stable until accept.
//   ready=1 -> WAIT, except ready=1 with resp_valid=1 in the same cycle -> DONE
//   (response taken).
//  WAIT: resp_valid=1 -> DONE; capture rdata (loads only) and resp_err.
//   resp_valid while bus_req_valid=0 and not in WAIT: ignored.
//  DONE: cpu_done=1 for exactly one cycle -> IDLE. cpu_fault=err|timeout.
//  Stall: cpu_stall = (cpu_req & state==IDLE & !bypass) | state in {ISSUE,WAIT}.
//   Goes low in the DONE cycle, so the pipeline advances the edge after DONE.
//  cpu_* inputs are ignored outside IDLE; no new capture in the DONE cycle.
//  cpu_rdata: registered; holds the last load value until the next load completes.
//   Forced to 0 on load fault. Stores leave it unchanged.
//  Timeout: counter clears on IDLE->ISSUE and increments each ISSUE/WAIT cycle.
//   When counter == TIMEOUT-1 with no completion that cycle -> DONE with fault=1.
//   If abandoned in ISSUE, bus_req_valid drops. Late responses are dropped.
//  Simultaneous completion and timeout: completion wins, fault=resp_err only.
//  Latency, zero-wait bus (ready=1, resp the next cycle):
//   req@c0, ISSUE@c1, WAIT@c2, DONE@c3. Stall is high for c0..c2.
//  Reset mid-transaction: immediate IDLE; bus_req_valid drops asynchronously.
//   No response is held over.
// TESTING
//  1. Load 0x1003, ready=1, rdata=0xDEADBEEF next cycle
//     -> bus_addr=0x1000, we=0; done@c3, rdata=0xDEADBEEF, fault=0.
//  2. Store 0x2002, wdata=0x00AB0000, wmask=0100, ready low 5 cycles
//     -> valid/addr/wstrb held stable 6 cycles; stall high until DONE.
//  3. Store with wmask=0000 -> DONE at c1, no bus_req_valid pulse, fault=0.
//  4. Load, resp never arrives, TIMEOUT=8 -> fault=1, rdata=0, done 8 cycles
//     after ISSUE entry; a late resp_valid is ignored and next request is clean.
//  5. Load gets resp_err=1, rdata=0x1234 -> fault=1, cpu_rdata=0.
//  6. rst_n low while in WAIT -> outputs 0 immediately; back-to-back loads after
//     release complete normally. Also check ready+resp in the same cycle -> DONE@c2.

Source files
------------

// File: rtl/dmem_bus_if.sv
// Data-memory bus seen by dmem_bus_ctrl: one request channel and one response channel,
// both using a valid/ready handshake.
interface dmem_bus_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;
    logic        bus_resp_err;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_rdata, bus_resp_err
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus controller: runs one load/store at a time on the data bus,
// stalls the pipeline while busy, and reports bus errors and timeouts.
module dmem_bus_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_cmd,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wmask,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_fault,
    dmem_bus_if.master  dbus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    state_t          state, state_nxt;
    req_t            req_q;
    logic [TO_W-1:0] to_cnt;
    logic            fault_q;
    logic            bypass;
    logic            complete;
    logic            timed_out;
    logic            busy;

    // A store with no enabled lanes has nothing to write: it completes without touching the bus.
    assign bypass = cpu_cmd & (cpu_wmask == 4'b0000);
    assign busy   = (state == ISSUE) | (state == WAIT);

    always_comb begin
        complete = 1'b0;
        case (state)
            ISSUE:   complete = dbus.bus_req_ready & dbus.bus_resp_valid;
            WAIT:    complete = dbus.bus_resp_valid;
            default: complete = 1'b0;
        endcase
    end

    // A response landing in the last allowed cycle still counts as completion.
    assign timed_out = busy & (to_cnt == TO_W'(TIMEOUT - 1)) & ~complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cpu_req) state_nxt = bypass ? DONE : ISSUE;
            end
            ISSUE: begin
                if (complete || timed_out)  state_nxt = DONE;
                else if (dbus.bus_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (complete || timed_out) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            to_cnt    <= '0;
            fault_q   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_q.we    <= cpu_cmd;
                        req_q.addr  <= cpu_addr & 32'hFFFF_FFFC;
                        req_q.wdata <= cpu_wdata;
                        req_q.wstrb <= cpu_wmask;
                        to_cnt      <= '0;
                        fault_q     <= 1'b0;
                    end
                end
                ISSUE, WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (complete) begin
                        fault_q <= dbus.bus_resp_err;
                        if (!req_q.we)
                            cpu_rdata <= dbus.bus_resp_err ? 32'h0 : dbus.bus_rdata;
                    end else if (timed_out) begin
                        fault_q <= 1'b1;
                        if (!req_q.we) cpu_rdata <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_done  = (state == DONE);
    assign cpu_fault = (state == DONE) & fault_q;
    assign cpu_stall = (cpu_req & (state == IDLE) & ~bypass) | busy;

    // Request fields come straight from the capture registers, so they hold until accept.
    assign dbus.bus_req_valid = (state == ISSUE);
    assign dbus.bus_addr      = req_q.addr;
    assign dbus.bus_we        = req_q.we;
    assign dbus.bus_wdata     = req_q.wdata;
    assign dbus.bus_wstrb     = req_q.wstrb;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench for dmem_bus_ctrl: a configurable bus responder plus directed
// transactions; expected completions are queued at issue and checked at cpu_done.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_cmd;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_stall, cpu_done, cpu_fault;
    logic [31:0] cpu_rdata;

    dmem_bus_if bif();

    dmem_bus_ctrl #(.TIMEOUT(8), .TO_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_cmd   (cpu_cmd),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wmask (cpu_wmask),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_fault (cpu_fault),
        .dbus      (bif.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        f;
        logic [31:0] rd;
    } exp_t;
    exp_t sb_q[$];

    // responder configuration
    int          rdy_wait = 0;
    int          resp_lat = 1;
    logic        resp_off = 1'b0;
    logic [31:0] r_data   = 32'h0;
    logic        r_err    = 1'b0;
    int          inj_req  = 0;
    int          inj_done = 0;

    logic [31:0] model_rd = 32'h0;

    initial begin
        int wc, pend;
        wc = 0; pend = 0;
        bif.bus_req_ready = 1'b0; bif.bus_resp_valid = 1'b0;
        bif.bus_rdata = 32'h0; bif.bus_resp_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            bif.bus_req_ready  = 1'b0;
            bif.bus_resp_valid = 1'b0;
            bif.bus_resp_err   = 1'b0;
            bif.bus_rdata      = $urandom;
            if (bif.bus_req_valid) begin
                pend = 0;
                if (wc < rdy_wait) wc++;
                else begin
                    bif.bus_req_ready = 1'b1;
                    if (!resp_off) begin
                        if (resp_lat == 0) begin
                            bif.bus_resp_valid = 1'b1; bif.bus_rdata = r_data; bif.bus_resp_err = r_err;
                        end else pend = resp_lat;
                    end
                end
            end else begin
                wc = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bif.bus_resp_valid = 1'b1; bif.bus_rdata = r_data; bif.bus_resp_err = r_err;
                    end
                end
            end
            if (inj_req != inj_done) begin
                inj_done = inj_req;
                bif.bus_resp_valid = 1'b1; bif.bus_resp_err = 1'b1; bif.bus_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_done === 1'b1) begin
            if (sb_q.size() == 0) chk("sb_unexpected_done", 1'b1, 1'b0);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_fault", cpu_fault, e.f);
                chk("sb_rdata", cpu_rdata, e.rd);
            end
        end
    end

    // Called one delta after a rising edge with the DUT in IDLE; returns likewise.
    task automatic run_txn(input string tag, input logic cmd, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] wm,
                           input logic ef, input int lat, input int nval);
        int   c0, vcnt, bad, stall_bad;
        logic byp;
        bit   got_done;
        exp_t e;
        byp = cmd && (wm == 4'b0000);
        if (!cmd) model_rd = ef ? 32'h0 : r_data;
        e.f = ef; e.rd = model_rd;
        sb_q.push_back(e);
        cpu_req = 1'b1; cpu_cmd = cmd; cpu_addr = addr; cpu_wdata = wd; cpu_wmask = wm;
        c0 = cyc; vcnt = 0; bad = 0; stall_bad = 0; got_done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_stall !== ((!byp && (cyc - c0) < lat) ? 1'b1 : 1'b0)) stall_bad++;
            if (cpu_fault === 1'b1 && cpu_done !== 1'b1) bad++;
            if (bif.bus_req_valid === 1'b1) begin
                vcnt++;
                if (bif.bus_addr !== (addr & 32'hFFFF_FFFC) || bif.bus_we !== cmd ||
                    bif.bus_wdata !== wd || bif.bus_wstrb !== wm) bad++;
            end
            if (cpu_done === 1'b1) begin got_done = 1; break; end
            @(posedge clk); #1;
            // inputs are junk outside IDLE and must not be captured
            cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wmask = 4'($urandom);
        end
        chk({tag, "_done_seen"}, got_done, 1'b1);
        chk({tag, "_latency"}, cyc - c0, lat);
        chk({tag, "_valid_cycles"}, vcnt, nval);
        chk({tag, "_bus_fields"}, bad, 0);
        chk({tag, "_stall"}, stall_bad, 0);
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_cmd = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {cpu_stall, cpu_done, cpu_fault, bif.bus_req_valid, cpu_rdata}, 64'h0);
        chk("reset_bus_addr", bif.bus_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait load
        rdy_wait = 0; resp_lat = 1; r_data = 32'hDEAD_BEEF; r_err = 0;
        run_txn("load_basic", 1'b0, 32'h0000_1003, 32'h0, 4'h0, 1'b0, 3, 1);

        // store held 5 cycles by ready low; store keeps cpu_rdata
        rdy_wait = 5; r_data = 32'h1111_1111;
        run_txn("store_wait", 1'b1, 32'h0000_2002, 32'h00AB_0000, 4'b0100, 1'b0, 8, 6);

        // empty-mask store bypasses the bus
        rdy_wait = 0;
        run_txn("store_nomask", 1'b1, 32'h0000_3000, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1, 0);

        // load with bus error forces cpu_rdata to 0
        r_data = 32'h0000_1234; r_err = 1;
        run_txn("load_err", 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 3, 1);

        // store with bus error faults but leaves cpu_rdata
        r_data = 32'h0; r_err = 1;
        run_txn("store_err", 1'b1, 32'h0000_4100, 32'hCAFE_0000, 4'b1100, 1'b1, 3, 1);
        r_err = 0;

        r_data = 32'h5A5A_A5A5;
        run_txn("load_pre_to", 1'b0, 32'h0000_5004, 32'h0, 4'h0, 1'b0, 3, 1);

        // timeout in WAIT
        resp_off = 1;
        run_txn("load_to_wait", 1'b0, 32'h0000_6000, 32'h0, 4'h0, 1'b1, 9, 1);
        inj_req++;
        begin
            int spur;
            spur = 0;
            repeat (3) begin @(negedge clk); if (cpu_done !== 1'b0 || cpu_stall !== 1'b0) spur++; end
            chk("late_resp_ignored", spur, 0);
            @(posedge clk); #1;
        end
        resp_off = 0;
        r_data = 32'h0BAD_F00D;
        run_txn("load_after_to", 1'b0, 32'h0000_6100, 32'h0, 4'h0, 1'b0, 3, 1);

        // ready never comes: valid held for the whole budget, then dropped
        rdy_wait = 100; resp_off = 1;
        run_txn("store_to_issue", 1'b1, 32'h0000_7000, 32'h1234_5678, 4'b1111, 1'b1, 9, 8);
        rdy_wait = 0; resp_off = 0;

        // response in the final allowed cycle: completion wins over timeout
        resp_lat = 7; r_data = 32'h7777_0001;
        run_txn("load_last_cycle", 1'b0, 32'h0000_7100, 32'h0, 4'h0, 1'b0, 9, 1);

        // ready and response in the same cycle
        resp_lat = 0; r_data = 32'h0C0F_FEE0;
        run_txn("load_same_cyc", 1'b0, 32'h0000_8008, 32'h0, 4'h0, 1'b0, 2, 1);

        // reset while in WAIT
        resp_lat = 1; resp_off = 1;
        cpu_req = 1'b1; cpu_cmd = 1'b0; cpu_addr = 32'h0000_9000;
        @(posedge clk); #1; cpu_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_stall", {cpu_stall, bif.bus_req_valid}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {cpu_stall, cpu_done, cpu_fault, bif.bus_req_valid, cpu_rdata}, 64'h0);
        chk("rst_async_addr", bif.bus_addr, 32'h0);
        model_rd = 32'h0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        resp_off = 0;
        @(posedge clk); #1;

        r_data = 32'hA1A1_0001;
        run_txn("b2b_load0", 1'b0, 32'h0000_A000, 32'h0, 4'h0, 1'b0, 3, 1);
        r_data = 32'hB2B2_0002;
        run_txn("b2b_load1", 1'b0, 32'h0000_A004, 32'h0, 4'h0, 1'b0, 3, 1);
        resp_lat = 0; r_data = 32'hC3C3_0003;
        run_txn("b2b_load2", 1'b0, 32'h0000_A00B, 32'h0, 4'h0, 1'b0, 2, 1);

        repeat (2) @(posedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
